// File: rtl/qam_demod_pkg.sv
// Shared encodings for the multi-mode QAM demodulator: modulation modes,
// FSM states and the bits-per-symbol lookup.
package qam_demod_pkg;

    typedef enum logic [1:0] {
        MODE_BPSK  = 2'd0,
        MODE_QPSK  = 2'd1,
        MODE_16QAM = 2'd2,
        MODE_64QAM = 2'd3
    } mode_e;

    typedef enum logic {
        S_READ  = 1'b0,
        S_WRITE = 1'b1
    } state_e;

    localparam int BPS_MAX = 6;

    function automatic int bps_of(input mode_e m);
        case (m)
            MODE_BPSK:  return 1;
            MODE_QPSK:  return 2;
            MODE_16QAM: return 4;
            default:    return 6;
        endcase
    endfunction

endpackage

// File: rtl/qam_slicer.sv
// Combinational hard slicer: per-axis Gray-coded decision, bits {I, Q}
// MSB-first, left-aligned in a 6-bit field with unused LSBs zero.
module qam_slicer
    import qam_demod_pkg::*;
#(
    parameter int DATA_W = 23,
    parameter int LEVEL  = 65536
) (
    input  logic signed [DATA_W-1:0] re,
    input  logic signed [DATA_W-1:0] im,
    input  mode_e                    mode,
    output logic [5:0]               bits
);

    typedef logic signed [DATA_W:0] ext_t;

    if (LEVEL * 6 >= (1 << (DATA_W - 1))) begin : g_level_too_large
        $error("qam_slicer: LEVEL*6 must be below 2^(DATA_W-1)");
    end

    // Region index = number of thresholds 2kL (|k|<=kmax) at or below v,
    // so a value exactly on a threshold falls into the upper region.
    function automatic logic [2:0] region(input ext_t v, input int kmax);
        logic [2:0] r;
        r = '0;
        for (int k = -3; k <= 3; k++) begin
            if (k >= -kmax && k <= kmax && v >= ext_t'(2 * k * LEVEL))
                r = r + 3'd1;
        end
        return r;
    endfunction

    function automatic logic [2:0] gray(input logic [2:0] r);
        return r ^ (r >> 1);
    endfunction

    ext_t       re_x, im_x;
    logic [2:0] g16_i, g16_q, g64_i, g64_q;

    always_comb begin
        re_x  = ext_t'(re);
        im_x  = ext_t'(im);
        g16_i = gray(region(re_x, 1));
        g16_q = gray(region(im_x, 1));
        g64_i = gray(region(re_x, 3));
        g64_q = gray(region(im_x, 3));
        case (mode)
            MODE_BPSK:  bits = {~re_x[DATA_W], 5'b0};
            MODE_QPSK:  bits = {~re_x[DATA_W], ~im_x[DATA_W], 4'b0};
            MODE_16QAM: bits = {g16_i[1:0], g16_q[1:0], 2'b0};
            default:    bits = {g64_i, g64_q};
        endcase
    end

endmodule

// File: rtl/axis_qam_demod_mm.sv
// Multi-mode AXI4-Stream QAM demodulator: collects one frame of symbols,
// slices the kept band into a bit buffer, then streams it out in OUT_W beats.
module axis_qam_demod_mm
    import qam_demod_pkg::*;
#(
    parameter  int DATA_W   = 23,
    parameter  int N_FFT    = 64,
    parameter  int SC_FIRST = 1,
    parameter  int SC_NUM   = 31,
    parameter  int LEVEL    = 65536,
    parameter  int OUT_W    = 32,
    localparam int IW       = 2 * 8 * ((DATA_W + 7) / 8)
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic             s_axis_tready,
    input  logic [IW-1:0]    s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    input  logic             m_axis_tready,
    output logic [OUT_W-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    output logic             frame_err
);

    localparam int SC_W   = $clog2(N_FFT);
    localparam int NB_MAX = (SC_NUM * BPS_MAX + OUT_W - 1) / OUT_W;
    localparam int PAD_W  = NB_MAX * OUT_W;
    localparam int BEAT_W = $clog2(NB_MAX + 1);

    state_e            state;
    logic [SC_W-1:0]   sc;
    logic [BEAT_W-1:0] beat;
    mode_e             mode_q;
    logic [PAD_W-1:0]  sbuf;
    logic              err_q;

    mode_e             mode_eff;
    logic [5:0]        sym_bits;
    logic [PAD_W-1:0]  sym_al, buf_nxt, beat_word;
    logic              s_hs, m_hs, at_end, keep, last_beat;
    int                sc_i, bps_eff, nb_q;

    if (IW / 2 > DATA_W) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^{s_axis_tdata[IW/2-1:DATA_W], s_axis_tdata[IW-1:IW/2+DATA_W]};
    end

    // Mode is taken live on the first symbol so that symbol slices correctly.
    assign mode_eff = (sc == '0) ? mode_e'(mode) : mode_q;

    qam_slicer #(.DATA_W(DATA_W), .LEVEL(LEVEL)) u_slicer (
        .re   ($signed(s_axis_tdata[DATA_W-1:0])),
        .im   ($signed(s_axis_tdata[IW/2 +: DATA_W])),
        .mode (mode_eff),
        .bits (sym_bits)
    );

    assign s_axis_tready = en & (state == S_READ);
    assign m_axis_tvalid = en & (state == S_WRITE);
    assign s_hs          = s_axis_tvalid & s_axis_tready;
    assign m_hs          = m_axis_tvalid & m_axis_tready;
    assign at_end        = (sc == SC_W'(N_FFT - 1));
    assign sc_i          = int'(sc);
    assign keep          = (sc_i >= SC_FIRST) && (sc_i < SC_FIRST + SC_NUM);
    assign bps_eff       = bps_of(mode_eff);
    assign nb_q          = (SC_NUM * bps_of(mode_q) + OUT_W - 1) / OUT_W;
    assign last_beat     = (int'(beat) == nb_q - 1);
    assign sym_al        = {sym_bits, {(PAD_W - BPS_MAX){1'b0}}};

    // Stream bit i lives at sbuf[PAD_W-1-i]; slicer zero-fills unused bits,
    // so OR-ing each symbol into a cleared buffer is safe.
    always_comb begin
        buf_nxt = (sc == '0) ? '0 : sbuf;
        if (keep)
            buf_nxt = buf_nxt | (sym_al >> ((sc_i - SC_FIRST) * bps_eff));
    end

    assign beat_word     = sbuf << (int'(beat) * OUT_W);
    assign m_axis_tdata  = m_axis_tvalid ? beat_word[PAD_W-1 -: OUT_W] : '0;
    assign m_axis_tlast  = m_axis_tvalid & last_beat;
    assign frame_err     = err_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state  <= S_READ;
            sc     <= '0;
            beat   <= '0;
            mode_q <= MODE_BPSK;
            sbuf   <= '0;
            err_q  <= 1'b0;
        end else if (en) begin
            err_q <= 1'b0;
            case (state)
                S_READ: if (s_hs) begin
                    sbuf  <= buf_nxt;
                    err_q <= s_axis_tlast ^ at_end;
                    if (sc == '0)
                        mode_q <= mode_e'(mode);
                    if (s_axis_tlast || at_end) begin
                        state <= S_WRITE;
                        sc    <= '0;
                    end else begin
                        sc <= sc + SC_W'(1);
                    end
                end
                default: if (m_hs) begin
                    if (last_beat) begin
                        state <= S_READ;
                        beat  <= '0;
                    end else begin
                        beat <= beat + BEAT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule
